mc_ctrl: RTL

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset control unit.
// Sequences FETCH -> DECODE -> EXEC -> MEM -> WB for addu, subu, ori, lui, lw, sw, beq, j, jal
// and jr, and counts retired instructions.
// Optional build macro MC_CTRL_MEMHS_EN: MEM waits for mem_ready before completing; without it
// MEM always lasts one cycle and mem_ready is ignored.
module mc_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ir_en,
  output logic        reg_we,
  output logic        mem_we,
  output logic [1:0]  npc_sel,
  output logic [1:0]  a3_sel,
  output logic        b_sel,
  output logic [1:0]  wd3_sel,
  output logic [2:0]  alu_op,
  output logic [1:0]  ext_op,
  output logic        mem_req,
  output logic        done,
  output logic        illegal,
  output logic [31:0] instr_cnt
);

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb
  } state_e;

  state_e state;

  logic is_rtype;
  logic is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic is_legal, is_jump;
  logic mem_done;

  // Instruction decode from the IR-held opcode/function fields.
  always_comb begin
    is_rtype = (op == 6'b000000);
    is_addu  = is_rtype && (funct == 6'b100001);
    is_subu  = is_rtype && (funct == 6'b100011);
    is_jr    = is_rtype && (funct == 6'b001000);
    is_ori   = (op == 6'b001101);
    is_lui   = (op == 6'b001111);
    is_lw    = (op == 6'b100011);
    is_sw    = (op == 6'b101011);
    is_beq   = (op == 6'b000100);
    is_j     = (op == 6'b000010);
    is_jal   = (op == 6'b000011);
    is_jump  = is_j || is_jal || is_jr;
    is_legal = is_addu || is_subu || is_jr || is_ori || is_lui || is_lw || is_sw || is_beq ||
               is_j || is_jal;
  end

`ifdef MC_CTRL_MEMHS_EN
  assign mem_done = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_done         = 1'b1;
`endif

  // State sequencing and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StFetch;
      instr_cnt <= 32'd0;
    end else begin
      if (done) begin
        instr_cnt <= instr_cnt + 32'd1;
      end
      unique case (state)
        StFetch:  state <= StDecode;
        StDecode: state <= (is_jump || !is_legal) ? StFetch : StExec;
        StExec: begin
          if (is_beq) begin
            state <= StFetch;
          end else if (is_lw || is_sw) begin
            state <= StMem;
          end else begin
            state <= StWb;
          end
        end
        StMem: begin
          if (mem_done) begin
            state <= is_sw ? StFetch : StWb;
          end
        end
        StWb:     state <= StFetch;
        default:  state <= StFetch;
      endcase
    end
  end

  // Control outputs decoded from state and instruction; all forced low while in reset.
  always_comb begin
    pc_en   = 1'b0;
    ir_en   = 1'b0;
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    npc_sel = 2'b00;
    a3_sel  = 2'b00;
    b_sel   = 1'b0;
    wd3_sel = 2'b00;
    alu_op  = 3'b000;
    ext_op  = 2'b00;
    mem_req = 1'b0;
    done    = 1'b0;
    illegal = 1'b0;
    if (rst_n) begin
      unique case (state)
        StFetch: begin
          ir_en = 1'b1;
          pc_en = 1'b1;
        end
        StDecode: begin
          if (is_j || is_jal) begin
            pc_en   = 1'b1;
            npc_sel = 2'b10;
            done    = 1'b1;
          end
          if (is_jal) begin
            reg_we  = 1'b1;
            a3_sel  = 2'b10;
            wd3_sel = 2'b10;
          end
          if (is_jr) begin
            pc_en   = 1'b1;
            npc_sel = 2'b11;
            done    = 1'b1;
          end
          if (!is_legal) begin
            illegal = 1'b1;
          end
        end
        StExec: begin
          if (is_beq) begin
            alu_op  = 3'b001;
            pc_en   = zero;
            npc_sel = 2'b01;
            done    = 1'b1;
          end else if (is_lw || is_sw) begin
            b_sel  = 1'b1;
            ext_op = 2'b01;
          end else if (is_subu) begin
            alu_op = 3'b001;
          end else if (is_ori) begin
            alu_op = 3'b010;
            b_sel  = 1'b1;
          end else if (is_lui) begin
            alu_op = 3'b011;
            b_sel  = 1'b1;
            ext_op = 2'b10;
          end
        end
        StMem: begin
          mem_req = 1'b1;
          mem_we  = is_sw;
          done    = is_sw && mem_done;
        end
        StWb: begin
          reg_we  = 1'b1;
          a3_sel  = is_rtype ? 2'b01 : 2'b00;
          wd3_sel = is_lw ? 2'b01 : 2'b00;
          done    = 1'b1;
        end
        default: begin
          pc_en = 1'b0;
        end
      endcase
    end
  end

endmodule
